// File: rtl/clcd_pkg.sv
// Shared types and constants for the HD44780-over-PCF8574 I2C sequencer.
// Holds FSM encodings, backpack bit positions, the init entry layout and delay defaults.
package clcd_pkg;

  typedef enum logic [2:0] {
    POR_WAIT, INIT_FETCH, IDLE, HI_EN, HI_DIS, LO_EN, LO_DIS, EXEC_WAIT
  } state_t;

  typedef enum logic [1:0] {PH_START, PH_WAIT_HI, PH_WAIT_LO} phase_t;

  localparam int PCF_RS = 0;
  localparam int PCF_RW = 1;
  localparam int PCF_EN = 2;
  localparam int PCF_BL = 3;

  localparam int DLY_W = 13;
  localparam int POR_W = 16;

  localparam int T_POR_US_DEF    = 50_000;
  localparam int T_CMD_US_DEF    = 40;
  localparam int T_CLR_US_DEF    = 1_600;
  localparam int T_INIT_LONG_US  = 4_100;
  localparam int T_INIT_SHORT_US = 100;

  typedef struct packed {
    logic             nibble_only;
    logic [7:0]       data;
    logic [DLY_W-1:0] delay_us;
  } init_entry_t;

  function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic bl,
                                          input logic en, input logic rs);
    logic [7:0] b;
    b         = '0;
    b[7:4]    = nib;
    b[PCF_BL] = bl;
    b[PCF_EN] = en;
    b[PCF_RW] = 1'b0;
    b[PCF_RS] = rs;
    return b;
  endfunction

endpackage

// File: rtl/clcd_init_rom.sv
// HD44780 4-bit power-on initialisation list. Nibble-only entries carry the
// nibble in data[7:4]; the final entry flags the end of the sequence.
module clcd_init_rom
  import clcd_pkg::*;
#(
  parameter int T_CMD_US = T_CMD_US_DEF,
  parameter int T_CLR_US = T_CLR_US_DEF
) (
  input  logic [2:0]       i_idx,
  output logic             o_nibble_only,
  output logic [7:0]       o_data,
  output logic [DLY_W-1:0] o_delay_us,
  output logic             o_last
);

  init_entry_t w_entry;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_entry = '{nibble_only: 1'b1, data: 8'h30, delay_us: DLY_W'(T_INIT_SHORT_US)};
    o_last  = 1'b0;
    case (i_idx)
      3'd0: w_entry = '{1'b1, 8'h30, DLY_W'(T_INIT_LONG_US)};
      3'd3: w_entry = '{1'b1, 8'h20, DLY_W'(T_INIT_SHORT_US)};
      3'd4: w_entry = '{1'b0, 8'h28, DLY_W'(T_CMD_US)};
      3'd5: w_entry = '{1'b0, 8'h0C, DLY_W'(T_CMD_US)};
      3'd6: w_entry = '{1'b0, 8'h06, DLY_W'(T_CMD_US)};
      3'd7: begin
        w_entry = '{1'b0, 8'h01, DLY_W'(T_CLR_US)};
        o_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_nibble_only = w_entry.nibble_only;
  assign o_data        = w_entry.data;
  assign o_delay_us    = w_entry.delay_us;

endmodule

// File: rtl/clcd_i2c_sequencer.sv
// Splits HD44780 bytes into PCF8574 4-bit-mode writes, runs the power-on init
// list and execution delays, and hands one write at a time to the I2C master.
module clcd_i2c_sequencer
  import clcd_pkg::*;
#(
  parameter int         CLK_HZ   = 100_000_000,
  parameter logic [6:0] I2C_ADDR = 7'h27,
  parameter int         T_POR_US = T_POR_US_DEF,
  parameter int         T_CMD_US = T_CMD_US_DEF,
  parameter int         T_CLR_US = T_CLR_US_DEF
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] i_byte,
  input  logic       i_rs,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_backlight,
  output logic       o_init_done,
  output logic [6:0] o_addr,
  output logic [7:0] o_data,
  output logic       o_RW,
  output logic       o_valid,
  input  logic       i_busy
);

  localparam int TICK_DIV = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;
  logic              r_busy_meta, r_busy_sync;

  state_t            r_state;
  phase_t            r_phase;
  logic [POR_W-1:0]  r_por_cnt;
  logic [DLY_W-1:0]  r_dly_cnt, r_delay;
  logic [2:0]        r_init_idx;
  logic [7:0]        r_byte;
  logic              r_rs, r_bl, r_nib_only, r_last;
  logic              r_ready, r_valid, r_init_done;
  logic [7:0]        r_data;

  logic              w_rom_nib_only, w_rom_last, w_clr, w_is_en;
  logic [7:0]        w_rom_data, w_tx_data;
  logic [DLY_W-1:0]  w_rom_delay;
  logic [3:0]        w_nib;
  state_t            w_next_send;

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)     r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TICK_W'(1);
  end

  // i_busy comes from the master's clock domain; only r_busy_sync reaches the FSM.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_busy_meta <= 1'b0;
      r_busy_sync <= 1'b0;
    end else begin
      r_busy_meta <= i_busy;
      r_busy_sync <= r_busy_meta;
    end
  end

  clcd_init_rom #(.T_CMD_US(T_CMD_US), .T_CLR_US(T_CLR_US)) u_rom (
    .i_idx         (r_init_idx),
    .o_nibble_only (w_rom_nib_only),
    .o_data        (w_rom_data),
    .o_delay_us    (w_rom_delay),
    .o_last        (w_rom_last)
  );

  assign w_clr     = !i_rs && (i_byte >= 8'h01) && (i_byte <= 8'h03);
  assign w_is_en   = (r_state == HI_EN) || (r_state == LO_EN);
  assign w_nib     = (r_state == HI_EN || r_state == HI_DIS) ? r_byte[7:4] : r_byte[3:0];
  assign w_tx_data = pcf_byte(w_nib, r_bl, w_is_en, r_rs);

  always_comb begin
    w_next_send = EXEC_WAIT;
    case (r_state)
      HI_EN:   w_next_send = HI_DIS;
      HI_DIS:  w_next_send = r_nib_only ? EXEC_WAIT : LO_EN;
      LO_EN:   w_next_send = LO_DIS;
      default: w_next_send = EXEC_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state     <= POR_WAIT;
      r_phase     <= PH_START;
      r_por_cnt   <= '0;
      r_dly_cnt   <= '0;
      r_delay     <= '0;
      r_init_idx  <= '0;
      r_byte      <= '0;
      r_rs        <= 1'b0;
      r_bl        <= 1'b0;
      r_nib_only  <= 1'b0;
      r_last      <= 1'b0;
      r_ready     <= 1'b0;
      r_valid     <= 1'b0;
      r_init_done <= 1'b0;
      r_data      <= '0;
    end else begin
      case (r_state)
        POR_WAIT: if (w_tick) begin
          if (r_por_cnt == POR_W'(T_POR_US - 1)) begin
            r_por_cnt <= '0;
            r_state   <= INIT_FETCH;
          end else begin
            r_por_cnt <= r_por_cnt + POR_W'(1);
          end
        end
        INIT_FETCH: begin
          r_byte     <= w_rom_data;
          r_rs       <= 1'b0;
          r_bl       <= i_backlight;
          r_nib_only <= w_rom_nib_only;
          r_delay    <= w_rom_delay;
          r_last     <= w_rom_last;
          r_phase    <= PH_START;
          r_state    <= HI_EN;
        end
        IDLE: if (i_valid && r_ready) begin
          r_byte     <= i_byte;
          r_rs       <= i_rs;
          r_bl       <= i_backlight;
          r_nib_only <= 1'b0;
          r_last     <= 1'b0;
          r_delay    <= w_clr ? DLY_W'(T_CLR_US) : DLY_W'(T_CMD_US);
          r_ready    <= 1'b0;
          r_phase    <= PH_START;
          r_state    <= HI_EN;
        end
        HI_EN, HI_DIS, LO_EN, LO_DIS: begin
          case (r_phase)
            PH_START: begin
              r_data  <= w_tx_data;
              r_valid <= 1'b1;
              r_phase <= PH_WAIT_HI;
            end
            PH_WAIT_HI: if (r_busy_sync) begin
              r_valid <= 1'b0;
              r_phase <= PH_WAIT_LO;
            end
            default: if (!r_busy_sync) begin
              r_dly_cnt <= '0;
              r_phase   <= PH_START;
              r_state   <= w_next_send;
            end
          endcase
        end
        EXEC_WAIT: if (w_tick) begin
          if (r_dly_cnt + DLY_W'(1) >= r_delay) begin
            r_dly_cnt <= '0;
            if (r_init_done || r_last) begin
              r_init_done <= 1'b1;
              r_ready     <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_init_idx <= r_init_idx + 3'd1;
              r_state    <= INIT_FETCH;
            end
          end else begin
            r_dly_cnt <= r_dly_cnt + DLY_W'(1);
          end
        end
        default: r_state <= POR_WAIT;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = r_valid;
  assign o_init_done = r_init_done;
  assign o_data      = r_data;
  assign o_addr      = I2C_ADDR;
  assign o_RW        = 1'b0;

endmodule

// File: tb/tb_clcd_i2c_sequencer.sv
// Self-checking bench for clcd_i2c_sequencer: behavioural I2C master, write
// scoreboard, table-driven byte vectors and reset/back-to-back corner cases.
module tb_clcd_i2c_sequencer;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic [7:0] i_byte = 8'h00;
  logic       i_rs = 1'b0, i_valid = 1'b0, i_backlight = 1'b1, i_busy = 1'b0;
  logic       o_ready, o_init_done, o_RW, o_valid;
  logic [6:0] o_addr;
  logic [7:0] o_data;

  always #5 clk = ~clk;

  clcd_i2c_sequencer #(
    .CLK_HZ(1_000_000), .I2C_ADDR(7'h27), .T_POR_US(10), .T_CMD_US(40), .T_CLR_US(1600)
  ) dut (
    .clk(clk), .reset_p(reset_p), .i_byte(i_byte), .i_rs(i_rs), .i_valid(i_valid),
    .o_ready(o_ready), .i_backlight(i_backlight), .o_init_done(o_init_done),
    .o_addr(o_addr), .o_data(o_data), .o_RW(o_RW), .o_valid(o_valid), .i_busy(i_busy)
  );

  typedef struct packed {
    logic [7:0]  b;
    logic        rs;
    logic        bl;
    logic [31:0] w;
    logic [15:0] wait_us;
  } vec_t;

  localparam int W_READY = 0, W_VALID = 1, W_INIT = 2, W_LO_EN = 3;

  int         n_tests = 0, n_fail = 0;
  int         cyc = 0, last_fall = 0, m_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_exp, m_hold;
  logic       m_prev_v = 1'b0, m_stable = 1'b1;
  vec_t       vecs[7];
  logic [7:0] init_w[24];
  int         b2b_sel[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      W_READY: return o_ready;
      W_VALID: return o_valid;
      W_INIT:  return o_init_done;
      default: return o_valid && (o_data == 8'h1D);
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int budget, input string name);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cond(sel)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles", name, budget);
    end
  endtask

  task automatic push_writes(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Master model: busy rises 3 cycles after a request is seen and lasts 20 cycles.
  always @(negedge clk) begin
    if (reset_p) begin
      m_cnt  = 0;
      i_busy = 1'b0;
    end else if (m_cnt == 0) begin
      if (o_valid) m_cnt = 1;
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 4) i_busy = 1'b1;
      if (m_cnt == 24) begin
        i_busy    = 1'b0;
        m_cnt     = 0;
        last_fall = cyc;
      end
    end
  end

  // Write monitor and scoreboard.
  always @(negedge clk) begin
    if (o_valid && !m_prev_v) begin
      check("valid_rise_while_busy", i_busy, 0);
      check("write_addr", o_addr, 7'h27);
      check("write_rw", o_RW, 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got %h expected none", o_data);
      end else begin
        m_exp = exp_q.pop_front();
        check("write_data", o_data, m_exp);
      end
      m_hold   = o_data;
      m_stable = 1'b1;
    end else if (o_valid && o_data !== m_hold) begin
      m_stable = 1'b0;
    end
    if (!o_valid && m_prev_v) check("data_stable", m_stable, 1);
    m_prev_v = o_valid;
  end

  task automatic run_init(input string tag);
    int t0;
    foreach (init_w[i]) exp_q.push_back(init_w[i]);
    reset_p = 1'b0;
    t0 = cyc;
    wait_cond(W_VALID, 100, {tag, "_por"});
    check_rng({tag, "_por_wait"}, cyc - t0, 10, 16);
    wait_cond(W_INIT, 10000, {tag, "_init"});
    check_rng({tag, "_init_done_delay"}, cyc - last_fall, 1599, 1605);
    check_rng({tag, "_init_total"}, cyc - t0, 6760, 6810);
    check({tag, "_ready_after_init"}, o_ready, 1);
    check({tag, "_init_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic send_vec(input vec_t v, input int idx);
    wait_cond(W_READY, 200, $sformatf("pre_ready_%0d", idx));
    i_byte = v.b; i_rs = v.rs; i_backlight = v.bl; i_valid = 1'b1;
    push_writes(v.w);
    @(negedge clk);
    check($sformatf("ready_fall_%0d", idx), o_ready, 0);
    i_byte = ~v.b; i_rs = ~v.rs; i_backlight = ~v.bl;
    repeat (20) @(negedge clk);
    i_valid = 1'b0;
    wait_cond(W_READY, 3000, $sformatf("exec_ready_%0d", idx));
    check_rng($sformatf("exec_wait_%0d", idx), cyc - last_fall,
              int'(v.wait_us) - 1, int'(v.wait_us) + 5);
    check($sformatf("writes_left_%0d", idx), exp_q.size(), 0);
  endtask

  initial begin
    int k, guard;
    vecs[0] = '{8'h41, 1'b1, 1'b1, 32'h4D491D19, 16'd40};
    vecs[1] = '{8'h01, 1'b0, 1'b0, 32'h04001410, 16'd1600};
    vecs[2] = '{8'h03, 1'b0, 1'b1, 32'h0C083C38, 16'd1600};
    vecs[3] = '{8'h04, 1'b0, 1'b1, 32'h0C084C48, 16'd40};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 32'h05011511, 16'd40};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 32'h04000400, 16'd40};
    vecs[6] = '{8'h5A, 1'b1, 1'b1, 32'h5D59ADA9, 16'd40};
    init_w = '{8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
               8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
               8'h0C, 8'h08, 8'h6C, 8'h68, 8'h0C, 8'h08, 8'h1C, 8'h18};
    b2b_sel = '{0, 4, 6};

    repeat (3) @(negedge clk);
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_init_done", o_init_done, 0);
    check("rst_data", o_data, 8'h00);
    check("rst_addr", o_addr, 7'h27);
    check("rst_rw", o_RW, 0);

    run_init("first");

    for (int i = 0; i < 7; i++) send_vec(vecs[i], i);

    // i_valid held high across three bytes.
    k = 0;
    guard = 0;
    i_byte = vecs[b2b_sel[0]].b; i_rs = vecs[b2b_sel[0]].rs;
    i_backlight = vecs[b2b_sel[0]].bl; i_valid = 1'b1;
    while (k < 3 && guard < 3000) begin
      if (o_ready) begin
        push_writes(vecs[b2b_sel[k]].w);
        @(negedge clk);
        check($sformatf("b2b_ready_fall_%0d", k), o_ready, 0);
        k++;
        if (k < 3) begin
          i_byte = vecs[b2b_sel[k]].b; i_rs = vecs[b2b_sel[k]].rs;
          i_backlight = vecs[b2b_sel[k]].bl;
        end else begin
          i_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    check("b2b_accepts", k, 3);
    i_valid = 1'b0;
    wait_cond(W_READY, 3000, "b2b_final_ready");
    check("b2b_writes_left", exp_q.size(), 0);

    // Reset while the low-nibble EN-high write is outstanding.
    wait_cond(W_READY, 200, "rst_pre_ready");
    i_byte = 8'h41; i_rs = 1'b1; i_backlight = 1'b1; i_valid = 1'b1;
    push_writes(32'h4D491D19);
    @(negedge clk);
    i_valid = 1'b0;
    wait_cond(W_LO_EN, 500, "reach_lo_en");
    #1;
    reset_p = 1'b1;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_init_done", o_init_done, 0);
    check("midrst_ready", o_ready, 0);
    check("midrst_writes_left", exp_q.size(), 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    run_init("second");

    send_vec(vecs[0], 7);
    check("init_done_sticky", o_init_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
